mem_dma: RTL and testbench

- Initiator for the single-port data memory: drives its write_enable/address/write_data port and samples read_data.
- Performs block copy (memmove semantics) or block fill of N 32-bit words, started by a start pulse from the control path.
- Sits between the control unit and the memory, and owns the memory port while busy.
- The memory read is combinational from address; the memory write commits at posedge clk when write_enable is high.

---
 rtl/mem_dma_pkg.sv | 16 +
 rtl/dma_addr_gen.sv | 41 ++++
 rtl/mem_dma.sv | 167 ++++++++++++++++
 tb/tb_mem_dma.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dma_pkg.sv
// rtl/mem_dma_pkg.sv - shared types and constants for the block copy/fill engine
package mem_dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/dma_addr_gen.sv
// rtl/dma_addr_gen.sv - loadable byte pointer that steps one word up or down
module dma_addr_gen
   import mem_dma_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] load_addr,
   input  logic        load_desc,
   input  logic        step,
   output logic [31:0] next_ptr
);

   logic [31:0] ptr_q, ptr_d;
   logic        desc_q, desc_d;

   // Direction is latched with the start address and holds for the whole transfer.
   always_comb begin
      ptr_d  = ptr_q;
      desc_d = desc_q;
      if (load) begin
         ptr_d  = load_addr;
         desc_d = load_desc;
      end else if (step) begin
         ptr_d = desc_q ? (ptr_q - WORD_BYTES) : (ptr_q + WORD_BYTES);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q  <= '0;
         desc_q <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         desc_q <= desc_d;
      end
   end

   assign next_ptr = ptr_d;

endmodule

// File: rtl/mem_dma.sv
// rtl/mem_dma.sv - memory-port initiator for word block copy (memmove) and fill
module mem_dma
   import mem_dma_pkg::*;
#(
   parameter int MEM_BYTES = 2048,
   parameter int LEN_W     = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len_words,
   input  logic [31:0]      fill_value,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [LEN_W-1:0] words_done,
   output logic             mem_write_enable,
   output logic [31:0]      mem_address,
   output logic [31:0]      mem_write_data,
   input  logic [31:0]      mem_read_data
);

   state_e           state_q, state_d;
   logic             busy_q, busy_d, done_q, done_d, err_q, err_d, we_q, we_d;
   logic [LEN_W-1:0] wd_q, wd_d, len_q, len_d;
   logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, fill_q, fill_d;
   logic             mode_q, mode_d;

   logic             src_load, dst_load, src_step, dst_step;
   logic [31:0]      src_next, dst_next;

   // End-address arithmetic is 33 bits wide so a huge base cannot wrap past the limit.
   logic [32:0] span, src_end, dst_end, limit;
   logic [31:0] last_ofs, src_start, dst_start;
   logic        reject, desc;

   always_comb begin
      span      = 33'({len_words, 2'b00});
      src_end   = {1'b0, src_addr} + span;
      dst_end   = {1'b0, dst_addr} + span;
      limit     = 33'(MEM_BYTES);
      last_ofs  = 32'({len_words, 2'b00}) - WORD_BYTES;
      reject    = (len_words == '0) || (dst_addr[1:0] != 2'b00) || (dst_end > limit) ||
                  ((mode == MODE_COPY) && ((src_addr[1:0] != 2'b00) || (src_end > limit)));
      desc      = (mode == MODE_COPY) && (dst_addr > src_addr) && ({1'b0, dst_addr} < src_end);
      src_start = desc ? (src_addr + last_ofs) : src_addr;
      dst_start = desc ? (dst_addr + last_ofs) : dst_addr;
   end

   dma_addr_gen u_src (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (src_load),
      .load_addr (src_start),
      .load_desc (desc),
      .step      (src_step),
      .next_ptr  (src_next)
   );

   dma_addr_gen u_dst (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (dst_load),
      .load_addr (dst_start),
      .load_desc (desc),
      .step      (dst_step),
      .next_ptr  (dst_next)
   );

   always_comb begin
      state_d  = state_q;
      err_d    = err_q;
      wd_d     = wd_q;
      len_d    = len_q;
      mode_d   = mode_q;
      fill_d   = fill_q;
      src_load = 1'b0;
      dst_load = 1'b0;
      src_step = 1'b0;
      dst_step = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d = mode;
               len_d  = len_words;
               fill_d = fill_value;
               wd_d   = '0;
               err_d  = reject;
               if (reject) begin
                  state_d = ST_DONE;
               end else begin
                  src_load = (mode == MODE_COPY);
                  dst_load = 1'b1;
                  state_d  = (mode == MODE_FILL) ? ST_WRITE : ST_READ;
               end
            end
         end
         ST_READ: begin
            src_step = 1'b1;
            state_d  = ST_WRITE;
         end
         ST_WRITE: begin
            dst_step = 1'b1;
            wd_d     = wd_q + 1'b1;
            if (wd_d == len_q)
               state_d = ST_DONE;
            else if (mode_q == MODE_COPY)
               state_d = ST_READ;
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so every port comes straight from a flop.
      busy_d  = (state_d == ST_READ) || (state_d == ST_WRITE);
      done_d  = (state_d == ST_DONE);
      we_d    = (state_d == ST_WRITE);
      addr_d  = '0;
      wdata_d = '0;
      if (state_d == ST_READ) begin
         addr_d = src_next;
      end else if (state_d == ST_WRITE) begin
         addr_d  = dst_next;
         wdata_d = (mode_d == MODE_FILL) ? fill_d : mem_read_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         wd_q    <= '0;
         len_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         fill_q  <= '0;
         mode_q  <= MODE_COPY;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         we_q    <= we_d;
         wd_q    <= wd_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         fill_q  <= fill_d;
         mode_q  <= mode_d;
      end
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign err              = err_q;
   assign words_done       = wd_q;
   assign mem_address      = addr_q;
   assign mem_write_data   = wdata_q;
   // A reset edge landing on a WRITE cycle must not commit that word.
   assign mem_write_enable = we_q & rst_n;

endmodule

// File: tb/tb_mem_dma.sv
// tb/tb_mem_dma.sv - scoreboard bench for mem_dma with a behavioural memory
module tb_mem_dma;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [31:0] src_addr = '0, dst_addr = '0, fill_value = '0;
   logic [9:0]  len_words = '0;
   logic        busy, done, err, mem_write_enable;
   logic [9:0]  words_done;
   logic [31:0] mem_address, mem_write_data, mem_read_data;

   logic [31:0] mem [0:511];
   logic        poke_en = 1'b0;
   logic [31:0] poke_addr = '0, poke_data = '0;

   int cyc = 0;
   int passed = 0;
   int total = 0;

   typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
   typedef struct { logic err; int wd; int cyc; } dn_t;
   wr_t wr_q[$];
   dn_t dn_q[$];

   mem_dma #(.MEM_BYTES(2048), .LEN_W(10)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .mode             (mode),
      .src_addr         (src_addr),
      .dst_addr         (dst_addr),
      .len_words        (len_words),
      .fill_value       (fill_value),
      .busy             (busy),
      .done             (done),
      .err              (err),
      .words_done       (words_done),
      .mem_write_enable (mem_write_enable),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign mem_read_data = mem[mem_address[10:2]];
   always @(posedge clk) begin
      if (mem_write_enable) mem[mem_address[10:2]] <= mem_write_data;
      else if (poke_en)     mem[poke_addr[10:2]]   <= poke_data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every write and every done pulse must match the next queued expectation.
   always @(negedge clk) begin
      if (mem_write_enable) begin
         if (wr_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_write: got addr %h data %h expected none", mem_address, mem_write_data);
         end else begin
            wr_t e;
            e = wr_q.pop_front();
            chk("wr_addr", mem_address, e.addr);
            chk("wr_data", mem_write_data, e.data);
         end
      end
      if (done) begin
         if (dn_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
         end else begin
            dn_t d;
            d = dn_q.pop_front();
            chk("done_err", {31'b0, err}, {31'b0, d.err});
            chk("done_words", {22'b0, words_done}, d.wd);
            chk("done_cycle", cyc, d.cyc);
            chk("done_not_busy", {31'b0, busy}, 32'd0);
         end
      end
   end

   task automatic poke(input logic [31:0] a, input logic [31:0] d);
      poke_en = 1'b1; poke_addr = a; poke_data = d;
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a; e.data = d;
      wr_q.push_back(e);
   endtask

   task automatic issue(input logic m, input logic [31:0] s, input logic [31:0] dd,
                        input logic [9:0] n, input logic [31:0] fv,
                        input logic e_err, input int extra, input logic e_done);
      dn_t d;
      mode = m; src_addr = s; dst_addr = dd; len_words = n; fill_value = fv; start = 1'b1;
      if (e_done) begin
         d.err = e_err; d.wd = e_err ? 0 : int'(n); d.cyc = cyc + 1 + extra;
         dn_q.push_back(d);
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int i;
      for (i = 0; i < 200; i++) begin
         if (wr_q.size() == 0 && dn_q.size() == 0) break;
         @(posedge clk); #1;
      end
      if (i == 200) begin
         total++;
         $display("FAIL %s_timeout: got %0d writes %0d dones pending expected 0", name, wr_q.size(), dn_q.size());
         wr_q.delete(); dn_q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_words", {22'b0, words_done}, 32'd0);
      chk("rst_we", {31'b0, mem_write_enable}, 32'd0);
      chk("rst_addr", mem_address, 32'd0);
      chk("rst_wdata", mem_write_data, 32'd0);
      rst_n = 1'b1;

      // Plain ascending copy
      poke(32'h400, 32'd11); poke(32'h404, 32'd22); poke(32'h408, 32'd33); poke(32'h40C, 32'd44);
      exp_wr(32'h600, 32'd11); exp_wr(32'h604, 32'd22); exp_wr(32'h608, 32'd33); exp_wr(32'h60C, 32'd44);
      issue(1'b0, 32'h400, 32'h600, 10'd4, 32'h0, 1'b0, 8, 1'b1);
      wait_idle("copy");
      for (int i = 0; i < 4; i++) chk("copy_mem", mem[(32'h600 >> 2) + i], 32'd11 * (i + 1));
      chk("copy_idle_words", {22'b0, words_done}, 32'd4);

      // Fill, word after the block must survive
      poke(32'h10C, 32'h55);
      exp_wr(32'h100, 32'hDEADBEEF); exp_wr(32'h104, 32'hDEADBEEF); exp_wr(32'h108, 32'hDEADBEEF);
      issue(1'b1, 32'h0, 32'h100, 10'd3, 32'hDEADBEEF, 1'b0, 3, 1'b1);
      wait_idle("fill");
      chk("fill_untouched", mem[32'h10C >> 2], 32'h55);

      // Overlapping copy forward by one word must run descending
      poke(32'h200, 32'd1); poke(32'h204, 32'd2); poke(32'h208, 32'd3); poke(32'h20C, 32'd4);
      exp_wr(32'h210, 32'd4); exp_wr(32'h20C, 32'd3); exp_wr(32'h208, 32'd2); exp_wr(32'h204, 32'd1);
      issue(1'b0, 32'h200, 32'h204, 10'd4, 32'h0, 1'b0, 8, 1'b1);
      wait_idle("memmove");
      for (int i = 0; i < 4; i++) chk("memmove_mem", mem[(32'h204 >> 2) + i], i + 1);
      chk("memmove_src0", mem[32'h200 >> 2], 32'd1);

      // Rejections
      issue(1'b0, 32'h400, 32'h602, 10'd1, 32'h0, 1'b1, 0, 1'b1);
      wait_idle("err_align");
      chk("err_held", {31'b0, err}, 32'd1);
      issue(1'b1, 32'h0, 32'h100, 10'd0, 32'h0, 1'b1, 0, 1'b1);
      wait_idle("err_len0");
      issue(1'b1, 32'h0, 32'h7FC, 10'd2, 32'h0, 1'b1, 0, 1'b1);
      wait_idle("err_dst_range");
      issue(1'b0, 32'h7FC, 32'h0, 10'd2, 32'h0, 1'b1, 0, 1'b1);
      wait_idle("err_src_range");
      issue(1'b0, 32'h402, 32'h0, 10'd1, 32'h0, 1'b1, 0, 1'b1);
      wait_idle("err_src_align");
      issue(1'b1, 32'h0, 32'hFFFF_FFF0, 10'd8, 32'h0, 1'b1, 0, 1'b1);
      wait_idle("err_wrap");

      // Ending exactly at the top of memory is legal, and clears err
      exp_wr(32'h7F8, 32'h12345678); exp_wr(32'h7FC, 32'h12345678);
      issue(1'b1, 32'h0, 32'h7F8, 10'd2, 32'h12345678, 1'b0, 2, 1'b1);
      wait_idle("fill_top");
      chk("err_cleared", {31'b0, err}, 32'd0);

      // Second start mid-transfer is ignored
      exp_wr(32'h700, 32'd11); exp_wr(32'h704, 32'd22); exp_wr(32'h708, 32'd33); exp_wr(32'h70C, 32'd44);
      issue(1'b0, 32'h400, 32'h700, 10'd4, 32'h0, 1'b0, 8, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      mode = 1'b1; dst_addr = 32'h0; len_words = 10'd1; fill_value = 32'hBAD0BAD0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle("restart");

      // Reset landing on the third write of an 8-word copy
      for (int i = 0; i < 8; i++) begin
         poke(32'h400 + 4 * i, 32'h100 + i);
         poke(32'h500 + 4 * i, 32'hAA);
      end
      exp_wr(32'h500, 32'h100); exp_wr(32'h504, 32'h101);
      issue(1'b0, 32'h400, 32'h500, 10'd8, 32'h0, 1'b0, 16, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("abort_in_write", {31'b0, mem_write_enable}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_we", {31'b0, mem_write_enable}, 32'd0);
      chk("abort_words", {22'b0, words_done}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      repeat (20) @(posedge clk);
      #1;
      chk("abort_writes_left", wr_q.size(), 32'd0);
      chk("abort_mem0", mem[32'h500 >> 2], 32'h100);
      chk("abort_mem1", mem[32'h504 >> 2], 32'h101);
      for (int i = 2; i < 8; i++) chk("abort_mem_rest", mem[(32'h500 >> 2) + i], 32'hAA);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
